// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: opcodes, FSM encoding and
// the illegal-operation screen used before results are returned.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_EQ   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_XNOR = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Upper half of the opcode space is reserved, an unknown opcode is never
  // trusted, and divide by zero has no meaningful result.
  function automatic logic is_illegal(input logic [3:0] op, input logic [7:0] b);
    return $isunknown(op) || op[3] || ((op == OP_DIV) && (b == 8'd0));
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two front-end sequencers and the
// arbiter. Requester i occupies lane i of every packed field.
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [7:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_result;
  logic        rsp_zero;
  logic        rsp_carry;
  logic        rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_err
  );
endinterface

// File: rtl/alu.sv
// Shared combinational 8-bit ALU. Carry is the add carry-out, the subtract
// borrow, or "product overflowed 8 bits" for multiply; zero tracks the result.
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] result,
  output logic       zero,
  output logic       carry
);

  logic [8:0]  sum;
  logic [15:0] prod;

  // Opcode decode and flag generation
  always_comb begin
    result = 8'd0;
    carry  = 1'b0;
    sum    = 9'd0;
    prod   = 16'd0;
    case (op)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[7:0];
        carry  = sum[8];
      end
      OP_SUB: begin
        sum    = {1'b0, a} - {1'b0, b};
        result = sum[7:0];
        carry  = sum[8];
      end
      OP_MUL: begin
        prod   = {8'd0, a} * {8'd0, b};
        result = prod[7:0];
        carry  = |prod[15:8];
      end
      OP_DIV:  result = (b == 8'd0) ? 8'hFF : a / b;
      OP_EQ:   result = {7'd0, (a == b)};
      OP_XOR:  result = a ^ b;
      OP_XNOR: result = ~(a ^ b);
      OP_AND:  result = a & b;
      default: result = 8'd0;
    endcase
    zero = (result == 8'd0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end sharing one ALU between two requesters. An accepted
// request is latched, executed for one cycle, then held as a response for
// its owner until that owner takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_arbiter_if.slave         bus,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [1:0] state_q;
  logic       ptr_q;
  logic       owner_p0;
  logic [7:0] a_p0;
  logic [7:0] b_p0;
  logic [3:0] op_p0;

  logic [7:0] result_p1;
  logic       zero_p1;
  logic       carry_p1;
  logic       err_p1;

  logic [1:0] grant;
  logic       grant_idx;
  logic       accept;
  logic       illegal;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       alu_carry;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + ERR_CNT_W'(1);
  endfunction

  // Grant the lone valid requester, or the pointer's pick on a tie
  always_comb begin
    grant = bus.req_valid;
    if (bus.req_valid == 2'b11) begin
      grant = ptr_q ? 2'b10 : 2'b01;
    end
    bus.req_ready = ((state_q == ST_IDLE) && !rst) ? grant : 2'b00;
  end

  assign grant_idx = grant[1];
  assign accept    = |(bus.req_valid & bus.req_ready);
  assign illegal   = is_illegal(op_p0, b_p0);

  // Stage p0: operand capture from the granted lane
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= grant_idx ? bus.req_a[15:8] : bus.req_a[7:0];
      b_p0  <= grant_idx ? bus.req_b[15:8] : bus.req_b[7:0];
      op_p0 <= grant_idx ? bus.req_op[7:4] : bus.req_op[3:0];
    end
  end

  alu u_alu (
    .a      (a_p0),
    .b      (b_p0),
    .op     (op_p0),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  // Stage p1: FSM, result capture with illegal screening, error counting
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      owner_p0  <= 1'b0;
      result_p1 <= 8'd0;
      zero_p1   <= 1'b0;
      carry_p1  <= 1'b0;
      err_p1    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            owner_p0 <= grant_idx;
            state_q  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (illegal) begin
            result_p1 <= 8'd0;
            zero_p1   <= 1'b0;
            carry_p1  <= 1'b0;
            err_p1    <= 1'b1;
            err_cnt   <= sat_inc(err_cnt);
          end else begin
            result_p1 <= alu_result;
            zero_p1   <= alu_zero;
            carry_p1  <= alu_carry;
            err_p1    <= 1'b0;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          // Only the owner can complete; the pointer then favours the other side
          if (bus.rsp_ready[owner_p0]) begin
            ptr_q   <= ~owner_p0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rsp_valid  = (state_q == ST_RESP) ? (owner_p0 ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_result = result_p1;
  assign bus.rsp_zero   = zero_p1;
  assign bus.rsp_carry  = carry_p1;
  assign bus.rsp_err    = err_p1;
  assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: accepted requests push a model result,
// response handshakes pop and compare. Error counter is kept narrow so its
// saturation is reachable.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int ECW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           busy;
  logic [ECW-1:0] err_cnt;

  alu_arbiter_if bus ();

  alu_arbiter #(.ERR_CNT_W(ECW)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .busy    (busy),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         owner;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       err;
  } exp_t;

  exp_t           sb[$];
  int             n_tests = 0;
  int             n_fail  = 0;
  int             cyc     = 0;
  int             last_acc = 0;
  int             acc_cyc[2];
  logic [1:0]     prev_rv = 2'b00;
  logic [ECW-1:0] exp_ec  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int o, input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op);
    exp_t        e;
    logic [15:0] p;
    e.owner  = o;
    e.result = 8'd0;
    e.zero   = 1'b0;
    e.carry  = 1'b0;
    e.err    = 1'b0;
    p = 16'(a) * 16'(b);
    if (op[3] || (op == 4'b0011 && b == 8'd0)) begin
      e.err = 1'b1;
    end else begin
      case (op)
        4'b0000: begin e.result = a + b; e.carry = (int'(a) + int'(b) > 255); end
        4'b0001: begin e.result = a - b; e.carry = (a < b); end
        4'b0010: begin e.result = p[7:0]; e.carry = (p > 16'd255); end
        4'b0011: e.result = a / b;
        4'b0100: e.result = (a == b) ? 8'd1 : 8'd0;
        4'b0101: e.result = a ^ b;
        4'b0110: e.result = ~(a ^ b);
        default: e.result = a & b;
      endcase
      e.zero = (e.result == 8'd0);
    end
    return e;
  endfunction

  // Scoreboard monitor: push on accept, pop on response handshake
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      sb.delete();
      exp_ec  = '0;
      prev_rv = 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb.push_back(model(i, bus.req_a[8*i +: 8], bus.req_b[8*i +: 8], bus.req_op[4*i +: 4]));
          acc_cyc[i] = cyc;
          last_acc   = cyc;
        end
      end
      if (bus.rsp_valid != 2'b00 && prev_rv == 2'b00)
        check("latency", 32'(cyc - last_acc), 2);
      if ((bus.rsp_valid & bus.rsp_ready) != 2'b00) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 0);
        end else begin
          e = sb.pop_front();
          if (e.err && exp_ec != '1) exp_ec = exp_ec + 1'b1;
          check("rsp_owner",  32'(bus.rsp_valid),  32'(e.owner == 1 ? 2'b10 : 2'b01));
          check("rsp_result", 32'(bus.rsp_result), 32'(e.result));
          check("rsp_zero",   32'(bus.rsp_zero),   32'(e.zero));
          check("rsp_carry",  32'(bus.rsp_carry),  32'(e.carry));
          check("rsp_err",    32'(bus.rsp_err),    32'(e.err));
          check("err_cnt",    32'(err_cnt),        32'(exp_ec));
        end
      end
      prev_rv = bus.rsp_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] op);
    bus.req_a[8*i +: 8]  = a;
    bus.req_b[8*i +: 8]  = b;
    bus.req_op[4*i +: 4] = op;
  endtask

  // Raise valid on the masked lanes and drop each one after its accept
  task automatic run_acc(input logic [1:0] mask);
    logic [1:0] pend;
    logic [1:0] got;
    pend = mask;
    bus.req_valid = bus.req_valid | mask;
    for (int k = 0; k < 60 && pend != 2'b00; k++) begin
      @(negedge clk);
      got = bus.req_valid & bus.req_ready & pend;
      step();
      bus.req_valid = bus.req_valid & ~got;
      pend = pend & ~got;
    end
    if (pend != 2'b00) check("accept_timeout", 32'(pend), 0);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (k >= 60) check("idle_timeout", 32'(busy), 0);
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    check({tag, "_result"},    32'(bus.rsp_result), 0);
    check({tag, "_zero"},      32'(bus.rsp_zero), 0);
    check({tag, "_carry"},     32'(bus.rsp_carry), 0);
    check({tag, "_err"},       32'(bus.rsp_err), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_err_cnt"},   32'(err_cnt), 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst           = 1'b1;
    bus.req_valid = 2'b00;
    bus.req_a     = 16'd0;
    bus.req_b     = 16'd0;
    bus.req_op    = 8'd0;
    bus.rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zeroed("reset");
    step();
    rst = 1'b0;

    // T1: single requester add, cycle-exact handshake timing
    set_req(0, 8'd5, 8'd3, OP_ADD);
    bus.req_valid = 2'b01;
    @(negedge clk);
    check("t1_req_ready", 32'(bus.req_ready), 32'(2'b01));
    step();
    bus.req_valid = 2'b00;
    @(negedge clk);
    check("t1_exec_no_rsp", 32'(bus.rsp_valid), 0);
    check("t1_busy", 32'(busy), 1);
    @(negedge clk);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 32'(2'b01));
    check("t1_result", 32'(bus.rsp_result), 8);
    check("t1_zero", 32'(bus.rsp_zero), 0);
    check("t1_err", 32'(bus.rsp_err), 0);
    wait_idle();

    // T2: simultaneous requests from a fresh pointer, back-to-back spacing
    step(); rst = 1'b1;
    step(); rst = 1'b0;
    set_req(0, 8'd10, 8'd7, OP_SUB);
    set_req(1, 8'd10, 8'd15, OP_XOR);
    run_acc(2'b11);
    wait_idle();
    check("t2_gap", 32'(acc_cyc[1] - acc_cyc[0]), 3);

    // T3: divide by zero rejected, then a legal compare
    step();
    set_req(0, 8'd10, 8'd0, OP_DIV);
    run_acc(2'b01);
    wait_idle();
    check("t3_err_cnt_div0", 32'(err_cnt), 1);
    step();
    set_req(0, 8'd5, 8'd5, OP_EQ);
    run_acc(2'b01);
    wait_idle();
    check("t3_err_cnt_hold", 32'(err_cnt), 1);

    // T4: reserved opcode from requester 1
    step();
    set_req(1, 8'h5A, 8'h33, 4'b1010);
    run_acc(2'b10);
    wait_idle();
    check("t4_err_cnt", 32'(err_cnt), 2);

    // T7: counter saturation, then a wrapping legal add
    step();
    set_req(0, 8'd9, 8'd9, 4'b1111);
    set_req(1, 8'd1, 8'd2, 4'b1000);
    run_acc(2'b11);
    wait_idle();
    step();
    set_req(1, 8'd4, 8'd0, OP_DIV);
    run_acc(2'b10);
    wait_idle();
    check("t7_sat", 32'(err_cnt), 3);
    step();
    set_req(1, 8'd255, 8'd1, OP_ADD);
    run_acc(2'b10);
    wait_idle();
    check("t7_sat_hold", 32'(err_cnt), 3);

    // T5: response backpressure with both requesters waiting
    step();
    bus.rsp_ready = 2'b00;
    set_req(0, 8'd200, 8'd100, OP_ADD);
    run_acc(2'b01);
    step();
    set_req(0, 8'd7, 8'd3, OP_MUL);
    set_req(1, 8'd16, 8'd16, OP_MUL);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      bus.rsp_ready = (k >= 3) ? 2'b10 : 2'b00;
      @(negedge clk);
      check("t5_hold_valid", 32'(bus.rsp_valid), 32'(2'b01));
      check("t5_hold_result", 32'(bus.rsp_result), 44);
      check("t5_hold_carry", 32'(bus.rsp_carry), 1);
      check("t5_hold_zero", 32'(bus.rsp_zero), 0);
      check("t5_hold_err", 32'(bus.rsp_err), 0);
      check("t5_req_ready", 32'(bus.req_ready), 0);
      check("t5_busy", 32'(busy), 1);
      step();
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    check("t5_release_valid", 32'(bus.rsp_valid), 32'(2'b01));
    step();
    @(negedge clk);
    check("t5_idle_busy", 32'(busy), 0);
    check("t5_idle_grant", 32'(bus.req_ready), 32'(2'b10));
    step();
    bus.req_valid[1] = 1'b0;
    run_acc(2'b01);
    wait_idle();

    // T6: reset during execution drops the operation and clears everything
    step();
    set_req(0, 8'd1, 8'd1, OP_ADD);
    run_acc(2'b01);
    rst = 1'b1;
    step();
    @(negedge clk);
    check_zeroed("t6");
    step();
    rst = 1'b0;
    set_req(0, 8'd9, 8'd4, OP_AND);
    set_req(1, 8'd9, 8'd4, OP_XNOR);
    bus.req_valid = 2'b11;
    @(negedge clk);
    check("t6_ptr_reset", 32'(bus.req_ready), 32'(2'b01));
    step();
    bus.req_valid[0] = 1'b0;
    run_acc(2'b10);
    wait_idle();
    repeat (4) @(negedge clk);
    check("t6_quiet", 32'(bus.rsp_valid), 0);
    check("sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
